// File: rtl/prog_loader_if.sv
// Program-memory write port driven by the serial program loader.
// The loader is the master; the memory (or a monitor) is the slave.
interface prog_loader_if;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;

    modport master (output mem_we, output mem_addr, output mem_data);
    modport slave  (input  mem_we, input  mem_addr, input  mem_data);
endinterface

// File: rtl/prog_loader.sv
// Serial 8N1 program loader: receives a SYNC/LEN/DATA/SUM frame, writes the data
// into a 256x8 program memory and holds the CPU in reset while loading.
module prog_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    prog_loader_if.master mem,
    output logic          cpu_reset,
    output logic          busy,
    output logic          load_ok,
    output logic          load_err
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_SUM} state_t;

    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t     rx_state_reg;
    logic [CW-1:0] clk_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;

    state_t        state_reg;
    logic [7:0]    addr_reg;
    logic [8:0]    remain_reg;
    logic [7:0]    sum_reg;
    logic          mem_we_reg;
    logic [7:0]    mem_addr_reg;
    logic [7:0]    mem_data_reg;
    logic          load_ok_reg, load_err_reg;
    logic          cpu_reset_reg;
    logic          booted_reg;

    logic          stop_tick, byte_ok, byte_bad;

    // Byte receiver: start detected on a synchronized falling edge, sampled at bit centers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            case (rx_state_reg)
                RX_IDLE: begin
                    clk_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg)
                        rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt_reg == CW'(HALF - 1)) begin
                        clk_cnt_reg  <= '0;
                        bit_idx_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_WAIT;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (rx_sync_reg)
                        rx_state_reg <= RX_IDLE;
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    assign stop_tick = (rx_state_reg == RX_STOP) && (clk_cnt_reg == CW'(CLKS_PER_BIT - 1));
    assign byte_ok   = stop_tick && rx_sync_reg;
    assign byte_bad  = stop_tick && !rx_sync_reg;

    // Frame FSM acts on the stop-bit sample, so its registered outputs land one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            remain_reg    <= '0;
            sum_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
            load_ok_reg   <= 1'b0;
            load_err_reg  <= 1'b0;
            cpu_reset_reg <= 1'b0;
            booted_reg    <= 1'b0;
        end else begin
            mem_we_reg   <= 1'b0;
            load_ok_reg  <= 1'b0;
            load_err_reg <= 1'b0;
            booted_reg   <= 1'b1;
            // Release the CPU on the first cycle out of reset and the cycle after a good load.
            if (!booted_reg || load_ok_reg)
                cpu_reset_reg <= 1'b1;
            if (byte_bad && state_reg != S_IDLE) begin
                load_err_reg <= 1'b1;
                state_reg    <= S_IDLE;
            end else if (byte_ok) begin
                case (state_reg)
                    S_IDLE: begin
                        if (shift_reg == SYNC_BYTE) begin
                            state_reg     <= S_LEN;
                            addr_reg      <= '0;
                            sum_reg       <= '0;
                            cpu_reset_reg <= 1'b0;
                        end
                    end
                    S_LEN: begin
                        remain_reg <= (shift_reg == 8'h00) ? 9'd256 : {1'b0, shift_reg};
                        state_reg  <= S_DATA;
                    end
                    S_DATA: begin
                        mem_we_reg   <= 1'b1;
                        mem_addr_reg <= addr_reg;
                        mem_data_reg <= shift_reg;
                        addr_reg     <= addr_reg + 1'b1;
                        sum_reg      <= sum_reg + shift_reg;
                        remain_reg   <= remain_reg - 1'b1;
                        if (remain_reg == 9'd1)
                            state_reg <= S_SUM;
                    end
                    S_SUM: begin
                        if (shift_reg == sum_reg)
                            load_ok_reg  <= 1'b1;
                        else
                            load_err_reg <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign mem.mem_we   = mem_we_reg;
    assign mem.mem_addr = mem_addr_reg;
    assign mem.mem_data = mem_data_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign busy         = (state_reg != S_IDLE);
    assign load_ok      = load_ok_reg;
    assign load_err     = load_err_reg;
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning: clk cycles per serial bit (50 MHz / 115200 baud).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, meaning: frame start marker.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk, takes effect that edge.
REQ-005 rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-006 mem_we  output  1  one-cycle write strobe to 256x8 program memory.
REQ-007 mem_addr  output  8  write address.
REQ-008 mem_data  output  8  write data.
REQ-009 cpu_reset  output  1  active-low reset to the CPU core; low while loading.
REQ-010 busy  output  1  high from SYNC_BYTE accepted until frame end.
REQ-011 load_ok  output  1  one-cycle pulse: frame complete, checksum matched.
REQ-012 load_err  output  1  one-cycle pulse: frame aborted (checksum or framing error).

Function
REQ-013 rx SHALL pass a 2-flop synchronizer before any use; total rx-to-sample latency 2 cycles.
REQ-014 Byte receiver SHALL start on a synchronized high-to-low transition while idle, recheck low at CLKS_PER_BIT/2, then sample 8 data bits every CLKS_PER_BIT cycles at bit centers.
REQ-015 Stop bit sampled low SHALL be a framing error: byte discarded, receiver returns to idle once rx is high.
REQ-016 A start bit that reads high at the half-bit check SHALL be ignored as a glitch.
REQ-017 Frame format SHALL be: SYNC_BYTE, LEN, LEN data bytes, SUM; LEN=0 means 256 bytes.
REQ-018 FSM states SHALL be IDLE, LEN, DATA, SUM; transitions on each received byte.
REQ-019 IDLE: byte == SYNC_BYTE -> LEN, clear address counter and checksum; any other byte ignored.
REQ-020 LEN: store count -> DATA.
REQ-021 DATA: each byte SHALL produce mem_we=1 for exactly one cycle, the cycle after the stop-bit sample, with mem_addr = counter, mem_data = byte; counter increments after the write; checksum += byte modulo 256.
REQ-022 After the LENth data byte -> SUM; address counter wraps 8'hFF->8'h00 only for LEN=0 and is then unused.
REQ-023 SUM: byte equal to checksum -> load_ok pulse; otherwise -> load_err pulse; both return to IDLE.
REQ-024 Framing error in LEN, DATA or SUM SHALL abort: load_err pulse, return to IDLE; memory already written is not restored.
REQ-025 cpu_reset SHALL go low the cycle after SYNC_BYTE is accepted and stay low through the frame; it returns high the cycle after load_ok. After load_err it stays low until the next load_ok or reset.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 load_ok and load_err SHALL never assert in the same cycle.
REQ-028 mem_we SHALL never assert outside DATA.

Reset
REQ-029 reset=0 SHALL force state IDLE, receiver idle, counter=0, checksum=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, load_ok=0, load_err=0, cpu_reset=0.
REQ-030 The cycle after reset returns high, cpu_reset SHALL go 1 so the CPU runs the existing memory contents.
REQ-031 reset mid-frame SHALL abandon the frame without a load_ok or load_err pulse.

Verification
REQ-032 Send A5,03,11,22,33,66 -> writes (00,11),(01,22),(02,33); one load_ok; cpu_reset low from A5 until the cycle after load_ok.
REQ-033 Send A5,02,01,02,FF -> two writes, load_err pulse, cpu_reset stays low, busy 0 afterwards.
REQ-034 Send A5,00, bytes 00..FF, checksum 80 -> 256 writes to addresses 00..FF, load_ok.
REQ-035 Send 55,A5,01,7E,7E -> 55 ignored; single write (00,7E); load_ok.
REQ-036 Send A5,02,10 then a byte with stop bit low -> one write (00,10), load_err, return to IDLE; a following valid frame loads normally.
REQ-037 Apply reset=0 during the 2nd data byte of a 4-byte frame -> no further mem_we, no pulse, all outputs at reset values, cpu_reset=1 one cycle after release.
